mem_io_responder: RTL and testbench

- Memory/IO slave on the CPU's byte-wide external bus. It receives the CPU-driven address, write strobe and write data, and drives the read-data byte back to the CPU.
- Contains the byte-addressed program/data RAM and the memory-mapped IO: UART TX byte queue, UART RX byte port, cycle counter and program-stop register.
- Drives io_buffer_full to the CPU.

---
 rtl/mem_io_responder_if.sv | 24 ++
 rtl/mem_io_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU external byte bus: request (address, strobe, write data) and the responder's return path.
interface mem_io_responder_if;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;

   modport master (
      output mem_a,
      output mem_wr,
      output mem_dout,
      input  mem_din,
      input  io_buffer_full
   );

   modport slave (
      input  mem_a,
      input  mem_wr,
      input  mem_dout,
      output mem_din,
      output io_buffer_full
   );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO slave for the CPU byte bus: program/data RAM, UART TX queue, UART RX port,
// cycle counter with coherent snapshot, and sticky program-stop register.
module mem_io_responder #(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   mem_io_responder_if.slave  bus,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               rx_ready,
   output logic               program_stop,
   output logic               tx_overflow
);

   localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned RAM_BYTES = 2 ** ADDR_W;

   logic [7:0]        ram [RAM_BYTES];
   logic [7:0]        fifo [TX_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  tx_count;
   logic [CNT_W-1:0]  count_next;
   logic [31:0]       cycle_cnt;
   logic [31:0]       snapshot;
   logic [7:0]        rd_byte;
   logic [7:0]        push_byte;
   logic              push;
   logic              pop;
   logic              accept;
   logic              fifo_full;

   logic              is_io;
   logic              io_data;
   logic              io_stop;
   logic              io_cnt;
   logic [ADDR_W-1:0] ram_addr;
   logic              unused_addr_bits;

   assign is_io    = (bus.mem_a[17:16] == 2'b11);
   assign io_data  = is_io && (bus.mem_a[15:0] == 16'h0000);
   assign io_stop  = is_io && (bus.mem_a[15:0] == 16'h0004);
   assign io_cnt   = is_io && (bus.mem_a[15:2] == 14'h0001);
   assign ram_addr = bus.mem_a[ADDR_W-1:0];
   assign unused_addr_bits = ^bus.mem_a[31:18];

   assign fifo_full = (tx_count == CNT_W'(TX_DEPTH));
   assign tx_valid  = (tx_count != '0);
   assign tx_data   = tx_valid ? fifo[rd_ptr] : 8'h00;
   assign pop       = tx_valid && tx_ready;
   assign rx_ready  = !rst_in && !bus.mem_wr && io_data && rx_valid;

   // TX push decode; the stop write injects a terminating 0x00 once.
   always_comb begin
      push      = 1'b0;
      push_byte = bus.mem_dout;
      if (bus.mem_wr && io_data && (bus.mem_dout != 8'h00)) begin
         push = 1'b1;
      end
      if (bus.mem_wr && io_stop && !program_stop) begin
         push      = 1'b1;
         push_byte = 8'h00;
      end
   end

   // A push into a full FIFO survives only if the head leaves in the same cycle.
   always_comb begin
      accept     = push && (!fifo_full || pop);
      count_next = tx_count;
      case ({accept, pop})
         2'b10:   count_next = tx_count + CNT_W'(1);
         2'b01:   count_next = tx_count - CNT_W'(1);
         default: count_next = tx_count;
      endcase
   end

   // Read data mux for the registered return byte.
   always_comb begin
      rd_byte = 8'h00;
      if (!is_io) begin
         rd_byte = ram[ram_addr];
      end else if (io_data) begin
         rd_byte = rx_valid ? rx_data : 8'h00;
      end else if (io_cnt) begin
         if (bus.mem_a[1:0] == 2'b00) begin
            rd_byte = cycle_cnt[7:0];
         end else begin
            rd_byte = snapshot[{bus.mem_a[1:0], 3'b000} +: 8];
         end
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in && bus.mem_wr && !is_io) begin
         ram[ram_addr] <= bus.mem_dout;
      end
   end

   // TX FIFO storage.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         fifo[wr_ptr] <= push_byte;
      end
   end

   // TX FIFO pointers, occupancy, near-full flag and overflow flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         tx_count           <= '0;
         bus.io_buffer_full <= 1'b0;
         tx_overflow        <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         tx_count           <= count_next;
         bus.io_buffer_full <= ((CNT_W'(TX_DEPTH) - count_next) <= CNT_W'(FULL_MARGIN));
         if (push && fifo_full && !pop) begin
            tx_overflow <= 1'b1;
         end
      end
   end

   // Registered read return; writes leave the previous byte in place.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bus.mem_din <= 8'h00;
      end else if (!bus.mem_wr) begin
         bus.mem_din <= rd_byte;
      end
   end

   // Free-running cycle counter, frozen after stop; a byte-0 read captures the snapshot.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt <= 32'h0;
         snapshot  <= 32'h0;
      end else begin
         if (!program_stop) begin
            cycle_cnt <= cycle_cnt + 32'h1;
         end
         if (!bus.mem_wr && io_cnt && (bus.mem_a[1:0] == 2'b00)) begin
            snapshot <= cycle_cnt;
         end
      end
   end

   // Sticky program-stop register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         program_stop <= 1'b0;
      end else if (bus.mem_wr && io_stop) begin
         program_stop <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table plus directed TX/counter/stop sequences.
module tb_mem_io_responder;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       program_stop;
   logic       tx_overflow;

   mem_io_responder_if bus ();

   mem_io_responder dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .bus          (bus),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .program_stop (program_stop),
      .tx_overflow  (tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int         chk;
      logic [7:0] exp;
   } din_t;

   typedef struct {
      logic [31:0] a;
      logic        wr;
      logic [7:0]  d;
      logic        rxv;
      logic [7:0]  rxd;
      logic        txr;
      int          chk;
      logic [7:0]  exp;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   bit          primed = 1'b0;
   logic [7:0]  tx_m [$];
   din_t        din_q [$];
   logic [31:0] cnt_m  = 32'h0;
   logic [31:0] snap_m = 32'h0;
   bit          stop_m = 1'b0;
   bit          ovf_m  = 1'b0;
   vec_t        vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus request; chk: 0 no mem_din check, 1 constant exp, 2 counter model.
   task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd, input logic txr,
                      input int chk, input logic [7:0] exp);
      logic       io;
      logic       pop;
      logic       push;
      logic [7:0] pb;
      int         sel;
      din_t       e;
      bus.mem_a    = a;
      bus.mem_wr   = wr;
      bus.mem_dout = d;
      rx_valid     = rxv;
      rx_data      = rxd;
      tx_ready     = txr;
      #1;
      io = (a[17:16] == 2'b11);
      if (primed) begin
         check("rx_ready", 32'(rx_ready), 32'(!rst_in && io && !wr && (a[15:0] == 16'h0) && rxv));
         check("tx_valid", 32'(tx_valid), 32'(tx_m.size() != 0));
         check("tx_data", 32'(tx_data), 32'((tx_m.size() != 0) ? tx_m[0] : 8'h00));
      end
      e.chk = chk;
      e.exp = exp;
      if (rst_in) begin
         e.chk = 1;
         e.exp = 8'h00;
      end else if (chk == 2) begin
         sel   = int'(a[1:0]);
         e.chk = 1;
         if (sel == 0) begin
            e.exp  = cnt_m[7:0];
            snap_m = cnt_m;
         end else begin
            e.exp = snap_m[8*sel +: 8];
         end
      end
      din_q.push_back(e);
      if (rst_in) begin
         tx_m.delete();
         cnt_m  = 32'h0;
         snap_m = 32'h0;
         stop_m = 1'b0;
         ovf_m  = 1'b0;
      end else begin
         pop  = (tx_m.size() != 0) && txr;
         push = 1'b0;
         pb   = d;
         if (io && wr && (a[15:0] == 16'h0) && (d != 8'h00)) push = 1'b1;
         if (io && wr && (a[15:0] == 16'h4) && !stop_m) begin
            push = 1'b1;
            pb   = 8'h00;
         end
         if (!stop_m) cnt_m = cnt_m + 32'h1;
         if (io && wr && (a[15:0] == 16'h4)) stop_m = 1'b1;
         if (pop) void'(tx_m.pop_front());
         if (push) begin
            if (tx_m.size() < 16) tx_m.push_back(pb);
            else ovf_m = 1'b1;
         end
      end
      @(posedge clk_in);
      #1;
      e = din_q.pop_front();
      if (e.chk != 0) check("mem_din", 32'(bus.mem_din), 32'(e.exp));
      check("io_buffer_full", 32'(bus.io_buffer_full), 32'((16 - tx_m.size()) <= 2));
      check("program_stop", 32'(program_stop), 32'(stop_m));
      check("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      cyc(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h00);
      rst_in = 1'b0;
      primed = 1'b1;
      check("reset tx_valid", 32'(tx_valid), 32'h0);
      check("reset tx_data", 32'(tx_data), 32'h0);
   endtask

   initial begin
      rst_in       = 1'b1;
      tx_ready     = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      bus.mem_a    = 32'h0;
      bus.mem_wr   = 1'b0;
      bus.mem_dout = 8'h00;

      //           addr        wr    data   rxv   rxd    txr  chk exp
      vecs[0]  = '{32'h00124, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1, 8'h00};
      vecs[1]  = '{32'h00123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1, 8'h00};
      vecs[2]  = '{32'h00123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'hA5};
      vecs[3]  = '{32'h00124, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h3C};
      vecs[4]  = '{32'h00123, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1, 8'h3C};
      vecs[5]  = '{32'h00123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h5A};
      vecs[6]  = '{32'h31234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h00};
      vecs[7]  = '{32'h30000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1, 8'h00};
      vecs[8]  = '{32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1, 8'h00};
      vecs[9]  = '{32'h30000, 1'b1, 8'h69, 1'b0, 8'h00, 1'b1, 1, 8'h00};
      vecs[10] = '{32'h30000, 1'b0, 8'h00, 1'b1, 8'h37, 1'b1, 1, 8'h37};
      vecs[11] = '{32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1, 8'h00};
      vecs[12] = '{32'h20123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1, 8'h5A};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].a, vecs[i].wr, vecs[i].d, vecs[i].rxv, vecs[i].rxd,
             vecs[i].txr, vecs[i].chk, vecs[i].exp);
      end

      // TX fill to near-full, overflow, push+pop while full, then drain.
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         cyc(32'h30000, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 0, 8'h00);
         if (i == 13) check("near_full_13", 32'(bus.io_buffer_full), 32'h0);
         if (i == 14) check("near_full_14", 32'(bus.io_buffer_full), 32'h1);
         if (i == 16) check("ovf_16", 32'(tx_overflow), 32'h0);
         if (i == 17) check("ovf_17", 32'(tx_overflow), 32'h1);
      end
      cyc(32'h30000, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 0, 8'h00);
      check("full_after_push_pop", 32'(bus.io_buffer_full), 32'h1);
      for (int i = 0; i < 20; i++) begin
         cyc(32'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, 8'h00);
      end
      check("drained", 32'(tx_valid), 32'h0);

      // Cycle counter snapshot after 300 cycles.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cyc(32'h00123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      end
      cyc(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h2C);
      cyc(32'h30005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h01);
      cyc(32'h30006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h00);
      cyc(32'h30007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h00);
      for (int i = 0; i < 5; i++) cyc(32'h00123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      cyc(32'h30005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h01);
      cyc(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2, 8'h00);
      cyc(32'h30005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2, 8'h00);

      // Program stop: 0x00 emitted, counter frozen, second stop ignored, reset clears queue.
      cyc(32'h30004, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 0, 8'h00);
      check("stop_set", 32'(program_stop), 32'h1);
      check("stop_zero_queued", 32'(tx_valid), 32'h1);
      cyc(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2, 8'h00);
      for (int i = 0; i < 5; i++) cyc(32'h00123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, 8'h00);
      cyc(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2, 8'h00);
      cyc(32'h30004, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      check("second_stop_ignored", 32'(tx_valid), 32'h0);
      cyc(32'h30000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      cyc(32'h30000, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      cyc(32'h30000, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 0, 8'h00);
      check("queued_before_reset", 32'(tx_valid), 32'h1);
      do_reset();
      check("stop_cleared", 32'(program_stop), 32'h0);
      cyc(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
